// File: rtl/instr_sequencer.sv
// Instruction-cycle sequencer: fetch, decode, indirect, memory-reference and
// register-reference execution, with halt/resume and a saturating T-state count.
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ir_in,
    input  logic        mem_ack,
    input  logic        exec_done,
    output logic [15:0] ir_out,
    output logic [3:0]  sc,
    output logic        ar_ld_pc,
    output logic        mem_rd,
    output logic        ir_ld,
    output logic        pc_inc,
    output logic        ar_ld_ir,
    output logic        ar_ld_mem,
    output logic        mri_start,
    output logic [2:0]  mri_op,
    output logic [11:0] rr_op,
    output logic        illegal,
    output logic        halted
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned SC_W    = 4;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned RR_W    = 12;

    localparam logic [OP_W-1:0] OP_REG = 3'b111;
    localparam logic [RR_W-1:0] RR_HLT = 12'h001;
    localparam logic [SC_W-1:0] SC_MAX = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_DECODE,
        S_INDIRECT,
        S_MRIEXEC,
        S_RREXEC,
        S_HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OP_W-1:0] opcode;
    logic            ind;
    logic [RR_W-1:0] rr_bits;
    logic            rr_onehot;
    logic            io_fault;

    assign opcode    = ir_out[14:12];
    assign ind       = ir_out[INSTR_W-1];
    assign rr_bits   = ir_out[RR_W-1:0];
    assign rr_onehot = (rr_bits != '0) && ((rr_bits & (rr_bits - RR_W'(1))) == '0);
    assign io_fault  = (state == S_DECODE) && (opcode == OP_REG) && ind;

    // Memory handshake strobes respond in the acknowledge cycle itself
    assign ir_ld     = (state == S_FETCH1) && mem_ack;
    assign pc_inc    = (state == S_FETCH1) && mem_ack;
    assign ar_ld_mem = (state == S_INDIRECT) && mem_ack;

    // Next-state selection; mri_start doubles as the first-MRIEXEC-cycle marker
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_FETCH0;
            S_FETCH0:   state_nxt = S_FETCH1;
            S_FETCH1:   if (mem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_REG) state_nxt = ind ? S_FETCH0 : S_RREXEC;
                else                  state_nxt = ind ? S_INDIRECT : S_MRIEXEC;
            end
            S_INDIRECT: if (mem_ack) state_nxt = S_MRIEXEC;
            S_MRIEXEC:  if (!mri_start && exec_done) state_nxt = S_FETCH0;
            S_RREXEC:   state_nxt = (rr_bits == RR_HLT) ? S_HALT : S_FETCH0;
            S_HALT:     if (start) state_nxt = S_FETCH0;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State register with state-decoded outputs registered alongside it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ar_ld_pc  <= 1'b0;
            mem_rd    <= 1'b0;
            ar_ld_ir  <= 1'b0;
            mri_start <= 1'b0;
            mri_op    <= '0;
            rr_op     <= '0;
            illegal   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ar_ld_pc  <= (state_nxt == S_FETCH0);
            mem_rd    <= (state_nxt == S_FETCH1) || (state_nxt == S_INDIRECT);
            ar_ld_ir  <= (state_nxt == S_DECODE);
            mri_start <= (state_nxt == S_MRIEXEC) && (state != S_MRIEXEC);
            mri_op    <= (state_nxt == S_MRIEXEC) ? opcode : '0;
            rr_op     <= ((state_nxt == S_RREXEC) && rr_onehot) ? rr_bits : '0;
            illegal   <= io_fault || ((state_nxt == S_RREXEC) && !rr_onehot);
            halted    <= (state_nxt == S_HALT);
        end
    end

    // Instruction register loads on the fetch acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_out <= '0;
        end else if ((state == S_FETCH1) && mem_ack) begin
            ir_out <= ir_in;
        end
    end

    // T-state counter: restarts with each fetch, parks at zero when idle/halted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc <= '0;
        end else if ((state_nxt == S_FETCH0) || (state_nxt == S_IDLE) || (state_nxt == S_HALT)) begin
            sc <= '0;
        end else if (sc != SC_MAX) begin
            sc <= sc + SC_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a driver issues instructions and memory
// replies, a monitor pops expected events whenever the DUT presents one.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] ir_in;
    logic        mem_ack;
    logic        exec_done;
    logic [15:0] ir_out;
    logic [3:0]  sc;
    logic        ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, mri_start;
    logic [2:0]  mri_op;
    logic [11:0] rr_op;
    logic        illegal, halted;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ir_in(ir_in), .mem_ack(mem_ack),
        .exec_done(exec_done), .ir_out(ir_out), .sc(sc), .ar_ld_pc(ar_ld_pc),
        .mem_rd(mem_rd), .ir_ld(ir_ld), .pc_inc(pc_inc), .ar_ld_ir(ar_ld_ir),
        .ar_ld_mem(ar_ld_mem), .mri_start(mri_start), .mri_op(mri_op), .rr_op(rr_op),
        .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam int K_DEC  = 1;
    localparam int K_MRI  = 2;
    localparam int K_RR   = 3;
    localparam int K_HALT = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          sc;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;
    logic prev_halted = 1'b0;

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    function automatic logic [63:0] pack(input int k, input logic [15:0] v, input int s);
        return {32'(k), v, 16'(s)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_ev(input int k, input logic [15:0] v, input int s);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.sc   = sat(s);
        exp_q.push_back(e);
    endtask

    task automatic match(input int k, input logic [15:0] v, input logic [3:0] s);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event", pack(k, v, int'(s)), 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("event", pack(k, v, int'(s)), pack(e.kind, e.val, e.sc));
        end
    endtask

    // Monitor: every presented DUT event is matched against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (ar_ld_ir) match(K_DEC, ir_out, sc);
            if (mri_start) match(K_MRI, {13'd0, mri_op}, sc);
            if ((rr_op != 12'd0) || illegal) match(K_RR, {3'b000, illegal, rr_op}, sc);
            if (halted && !prev_halted) match(K_HALT, 16'h0000, sc);
        end
        prev_halted <= halted;
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return mem_rd;
            1:       return mri_start;
            default: return halted;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk({"timeout_", name}, 64'd0, 64'd1);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_fetch0", {ar_ld_pc, mem_rd, sc}, {1'b1, 1'b0, 4'd0});
    endtask

    // Answer one memory read after d extra wait cycles; start noise must be ignored
    task automatic mem_reply(input logic [15:0] data, input int d, input bit is_fetch);
        bit ok;
        wait_sig("mem_rd", 0, ok);
        for (int i = 0; i < d; i++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start   = 1'b0;
        mem_ack = 1'b1;
        ir_in   = data;
        #1;
        if (is_fetch) chk("fetch_ack", {mem_rd, ir_ld, pc_inc, ar_ld_mem}, 4'b1110);
        else          chk("indirect_ack", {mem_rd, ir_ld, pc_inc, ar_ld_mem}, 4'b1001);
        @(negedge clk);
        mem_ack = 1'b0;
        ir_in   = 16'($urandom);
    endtask

    task automatic do_exec(input logic [2:0] opc, input int mri_sc, input int e);
        bit ok;
        wait_sig("mri_start", 1, ok);
        if (e == 0) begin
            exec_done = 1'b1;
            @(negedge clk);
            chk("mri_first_ignored", {mri_start, mri_op, sc, ar_ld_pc},
                {1'b0, opc, 4'(sat(mri_sc + 1)), 1'b0});
        end else begin
            repeat (e) @(negedge clk);
            chk("mri_wait", {mri_start, mri_op, sc, ar_ld_pc},
                {1'b0, opc, 4'(sat(mri_sc + e)), 1'b0});
            exec_done = 1'b1;
        end
        @(negedge clk);
        exec_done = 1'b0;
        chk("mri_exit", {ar_ld_pc, mri_op, sc}, {1'b1, 3'd0, 4'd0});
    endtask

    task automatic do_halt();
        bit ok;
        wait_sig("halted", 2, ok);
        repeat (10) @(negedge clk);
        chk("halt_hold", {halted, ar_ld_pc, mem_rd, sc}, {1'b1, 1'b0, 1'b0, 4'd0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("halt_resume", {halted, ar_ld_pc, sc}, {1'b0, 1'b1, 4'd0});
    endtask

    // Reference model: expected event sequence derived from the instruction word
    task automatic run_instr(input logic [15:0] instr, input int d1, input int d2, input int e);
        logic [2:0]  opc;
        logic        ind;
        logic [11:0] low;
        bit          hlt;
        opc = instr[14:12];
        ind = instr[15];
        low = instr[11:0];
        hlt = 1'b0;
        expect_ev(K_DEC, instr, d1 + 2);
        if (opc == 3'd7) begin
            if (ind) begin
                expect_ev(K_RR, 16'h1000, 0);
            end else begin
                if ($countones(low) == 1) expect_ev(K_RR, {4'h0, low}, d1 + 3);
                else                      expect_ev(K_RR, 16'h1000, d1 + 3);
                if (low == 12'h001) begin
                    hlt = 1'b1;
                    expect_ev(K_HALT, 16'h0000, 0);
                end
            end
            mem_reply(instr, d1, 1'b1);
            if (hlt) do_halt();
        end else begin
            expect_ev(K_MRI, {13'd0, opc}, ind ? (d1 + d2 + 4) : (d1 + 3));
            mem_reply(instr, d1, 1'b1);
            if (ind) mem_reply(16'($urandom), d2, 1'b0);
            do_exec(opc, ind ? (d1 + d2 + 4) : (d1 + 3), e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] instr;
        int          kind;
        bit          ok;
        reset = 1'b0; start = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; ir_in = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_state", {ir_out, sc, ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem,
                            mri_start, mri_op, rr_op, illegal, halted}, 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold", {ar_ld_pc, mem_rd, halted, sc}, 7'd0);
        mon_en = 1'b1;
        start_pulse();

        run_instr(16'h7020, 1, 0, 0);
        run_instr(16'h2005, 0, 0, 0);
        run_instr(16'hA005, 2, 1, 3);
        run_instr(16'h7003, 0, 0, 0);
        run_instr(16'hF400, 0, 0, 0);
        run_instr(16'h7001, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, 9));
            instr = 16'($urandom);
            if (kind <= 4) begin
                instr[14:12] = 3'($urandom_range(0, 6));
            end else if (kind <= 6) begin
                instr[15:12] = 4'h7;
                instr[11:0]  = 12'h1 << $urandom_range(1, 11);
            end else if (kind == 7) begin
                instr[15:12] = 4'h7;
            end else if (kind == 8) begin
                instr[15:12] = 4'hF;
            end else begin
                instr = 16'h7001;
            end
            run_instr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)));
        end

        // Long MRIEXEC wait saturates sc, then reset lands mid-wait
        expect_ev(K_DEC, 16'h3007, 2);
        expect_ev(K_MRI, 16'h0003, 3);
        mem_reply(16'h3007, 0, 1'b1);
        wait_sig("mri_start", 1, ok);
        repeat (20) @(negedge clk);
        chk("sc_saturate", {sc, mri_op, ar_ld_pc}, {4'd15, 3'd3, 1'b0});
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", {ir_out, sc, ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem,
                            mri_start, mri_op, rr_op, illegal, halted}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_reset", {ar_ld_pc, mem_rd, mri_start, halted, sc}, 8'd0);
        mon_en = 1'b1;
        start_pulse();
        run_instr(16'h1234, 1, 0, 2);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
